// File: rtl/acc_mcu_core.sv
// acc_mcu_core: minimal accumulator micro-controller with a single shared
// request/acknowledge memory port used for both instruction fetch and data.
//
// Instruction word: {op[3:0], c[AW-1:0]}, with AW = DW-4.
//   LD=0 (A=M[c])  ADD=1 (A+=M[c])  JMP=2  ST=3 (M[c]=A)  CMP=4
//   JEQ=5 (if Z)   JLT=6 (if N)     HALT=F  all other opcodes are NOPs
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   mem_req/mem_we      request valid (held until mem_ack) / write strobe
//   mem_addr/mem_wdata  request word address / store data (always A)
//   mem_rdata/mem_ack   read data / completion, both sampled in the same cycle
//   acc, pc, flags      accumulator, program counter, {N,Z}
//   halted              high while in HALT
//
// state  | meaning
// FETCH  | read M[pc]; on ack latch the instruction and advance pc
// DECODE | resolve jumps/NOP/HALT here; memory ops move on to MEM
// MEM    | data access at c; on ack update A/flags or finish the store
// HALT   | everything frozen, no requests, until reset

module acc_mcu_core #(
  parameter int DW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-5:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] acc,
  output logic [DW-5:0] pc,
  output logic [1:0]    flags,
  output logic          halted
);

  localparam int AW = DW - 4;
  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_JEQ  = 4'h5;
  localparam logic [3:0] OP_JLT  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          n_q, n_d;
  logic          z_q, z_d;

  logic [3:0]    op;
  logic [AW-1:0] c_field;

  assign op      = ir_q[DW-1:DW-4];
  assign c_field = ir_q[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC_W;
      acc_q   <= '0;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    ir_d     = ir_q;
    n_d      = n_q;
    z_d      = z_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // pc already points past this instruction; a taken jump replaces it.
        case (op)
          OP_JMP:  begin pc_d = c_field; state_d = S_FETCH; end
          OP_JEQ:  begin if (z_q) pc_d = c_field; state_d = S_FETCH; end
          OP_JLT:  begin if (n_q) pc_d = c_field; state_d = S_FETCH; end
          OP_LD, OP_ADD, OP_ST, OP_CMP: state_d = S_MEM;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = c_field;
        mem_we   = (op == OP_ST);
        if (mem_ack) begin
          case (op)
            OP_LD:  acc_d = mem_rdata;
            OP_ADD: acc_d = acc_q + mem_rdata;
            OP_CMP: begin
              z_d = (acc_q == mem_rdata);
              n_d = ($signed(acc_q) < $signed(mem_rdata));
            end
            default: ;
          endcase
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase

    // A request in flight when reset hits is dropped immediately.
    if (reset) mem_req = 1'b0;
  end

  assign mem_wdata = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign flags     = {n_q, z_q};
  assign halted    = (state_q == S_HALT);

endmodule

// File: doc/acc_mcu_core.md
ACC_MCU_CORE -- requirements
Module: acc_mcu_core

Interface
REQ-001 Parameter DW, default 16: data and instruction word width; SHALL be >= 8.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset; width AW.
REQ-003 Derived AW = DW-4: address/constant field width, instruction = {op[3:0], C[AW-1:0]}.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req  out  1  memory request valid; held until accepted by mem_ack.
REQ-007 mem_we  out  1  1 = write (ST data phase), 0 = read.
REQ-008 mem_addr  out  AW  word address of the request.
REQ-009 mem_wdata  out  DW  write data; equals A while a write request is pending.
REQ-010 mem_rdata  in  DW  read data; sampled in the cycle mem_ack=1.
REQ-011 mem_ack  in  1  completes the current request in that cycle; ignored when mem_req=0.
REQ-012 acc  out  DW  accumulator A.
REQ-013 pc  out  AW  program counter.
REQ-014 flags  out  2  {N,Z} status.
REQ-015 halted  out  1  1 while in HALT state.

Function
REQ-016 Opcodes SHALL be LD=0 (A=M[C]), ADD=1 (A=A+M[C]), JMP=2 (PC=C), ST=3 (M[C]=A), CMP=4, JEQ=5 (if Z PC=C), JLT=6 (if N PC=C), HALT=F; all others NOP.
REQ-017 FSM states SHALL be FETCH, DECODE, MEM, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ack, IR<=mem_rdata, PC<=PC+1 modulo 2^AW, go DECODE; else stay.
REQ-019 DECODE: JMP/JEQ/JLT/NOP complete here and go FETCH; HALT goes HALT; LD/ADD/ST/CMP go MEM.
REQ-020 MEM: mem_req=1, mem_addr=C, mem_we=1 only for ST; on mem_ack update A/flags (or complete write) and go FETCH.
REQ-021 mem_addr, mem_we, mem_wdata SHALL stay constant while mem_req=1 and mem_ack=0.
REQ-022 mem_ack in the same cycle mem_req rises SHALL be accepted (zero wait state); minimum latency 2 cycles for jump/NOP, 3 cycles for memory instructions.
REQ-023 ADD SHALL be modulo 2^DW; carry discarded; ADD and LD do not modify flags.
REQ-024 CMP SHALL set Z=(A==M[C]) and N=(A<M[C]) as signed two's-complement DW-bit values; A unchanged.
REQ-025 Taken jump in DECODE SHALL override the PC+1 from FETCH; not-taken leaves PC unchanged.
REQ-026 HALT SHALL hold all state, drive mem_req=0, halted=1, until reset.
REQ-027 mem_ack arriving while mem_req=0 SHALL have no effect.

Reset
REQ-028 While reset=1 at a clock edge: state<=FETCH, PC<=RESET_PC, A<=0, N<=0, Z<=0, IR<=0, halted<=0.
REQ-029 mem_req SHALL be 0 in any cycle reset=1, including mid-transaction; a pending request is abandoned and its ack ignored.
REQ-030 First fetch request (mem_addr=RESET_PC) SHALL be driven in the first cycle after reset deasserts.

Verification
REQ-031 DW=16, zero-wait memory, M[0]=0x0010,M[1]=0x1011,M[2]=0x3012,M[3]=0xF000, M[0x10]=0x0005,M[0x11]=0x0007 -> M[0x12]=0x000C, acc=0x000C, halted=1 after 11 cycles, pc=0x004.
REQ-032 CMP/JEQ: A=0x0005, M[0x20]=0x0005, CMP 0x020 then JEQ 0x040 -> flags=2'b01, next fetch address 0x040; with M[0x20]=0x0006 -> flags=2'b10, fetch continues sequentially.
REQ-033 Signed compare: A=0x8000, M[C]=0x0001, CMP -> N=1, Z=0; JLT taken.
REQ-034 Wait states: mem_ack delayed 3 cycles on every request -> mem_addr/mem_we/mem_wdata stable throughout, results identical to REQ-031, total cycles 11+3*7.
REQ-035 Wrap: RESET_PC=0xFFF, M[0xFFF]=NOP, M[0x000]=HALT -> fetches 0xFFF then 0x000, halted=1; ADD 0xFFFF+0x0002 -> acc=0x0001.
REQ-036 Reset mid-MEM with mem_ack withheld -> mem_req=0 that cycle, next request reads RESET_PC, acc=0, flags=0; late ack ignored.
